// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 raster timing defaults, coordinate type and total-length helper
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // Counters are 10 bits wide, so any timing set must keep both totals at or below this.
    localparam int COORD_LIMIT = 1024;

    typedef logic [9:0] coord_t;

    function automatic int timing_total(input int visible, input int front,
                                        input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - vertical-blank interrupt handshake and per-frame status bundle
interface vga_timing_gen_if;

    logic       vsync_toggle;
    logic       vblank_irq;
    logic       irq_ack;
    logic [7:0] missed_cnt;

    modport master (
        output vsync_toggle,
        output vblank_irq,
        output missed_cnt,
        input  irq_ack
    );

    modport slave (
        input  vsync_toggle,
        input  vblank_irq,
        input  missed_cnt,
        output irq_ack
    );

endinterface

// File: rtl/vga_sync_counter.sv
// rtl/vga_sync_counter.sv - pixel_ce-gated raster X/Y counter with wrap; exposes current and next coordinates
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pixel_ce,
    output coord_t x,
    output coord_t y,
    output coord_t next_x,
    output coord_t next_y
);

    coord_t x_q;
    coord_t x_d;
    coord_t y_q;
    coord_t y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pixel_ce) begin
            if (int'(x_q) == H_TOTAL - 1) begin
                x_d = '0;
                y_d = (int'(y_q) == V_TOTAL - 1) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign next_x = x_d;
    assign next_y = y_d;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing with sync/blank decode, vblank irq and frame toggle
// Optional missed-frame counter enabled by defining VGA_MISSED_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic             pixel_clk,
    output logic             pixel_ce,
    output coord_t           DrawX,
    output coord_t           DrawY,
    output logic             hs,
    output logic             vs,
    output logic             blank,
    vga_timing_gen_if.master irq_if
);

    localparam int H_TOTAL  = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    logic   pixel_clk_q;
    logic   pixel_clk_d;
    logic   hs_q;
    logic   hs_d;
    logic   vs_q;
    logic   vs_d;
    logic   blank_q;
    logic   blank_d;
    logic   toggle_q;
    logic   toggle_d;
    logic   irq_q;
    logic   irq_d;
    logic   vblank_start;
    coord_t next_x;
    coord_t next_y;

    vga_sync_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk      (CLK),
        .rst      (RESET),
        .pixel_ce (pixel_ce),
        .x        (DrawX),
        .y        (DrawY),
        .next_x   (next_x),
        .next_y   (next_y)
    );

    // Decode from next-state coordinates so the registered sync/blank line up with DrawX/DrawY.
    always_comb begin
        pixel_ce     = ~pixel_clk_q;
        pixel_clk_d  = ~pixel_clk_q;
        hs_d         = !((int'(next_x) >= HS_START) && (int'(next_x) < HS_END));
        vs_d         = !((int'(next_y) >= VS_START) && (int'(next_y) < VS_END));
        blank_d      = (int'(next_x) < H_VISIBLE) && (int'(next_y) < V_VISIBLE);
        vblank_start = pixel_ce && (next_x == '0) && (int'(next_y) == V_VISIBLE);
        toggle_d     = toggle_q ^ vblank_start;
        // A new vblank outranks an acknowledge arriving in the same cycle.
        irq_d        = vblank_start | (irq_q & ~irq_if.irq_ack);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pixel_clk_q <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b1;
            toggle_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            pixel_clk_q <= pixel_clk_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            toggle_q    <= toggle_d;
            irq_q       <= irq_d;
        end
    end

    assign pixel_clk           = pixel_clk_q;
    assign hs                  = hs_q;
    assign vs                  = vs_q;
    assign blank               = blank_q;
    assign irq_if.vsync_toggle = toggle_q;
    assign irq_if.vblank_irq   = irq_q;

`ifdef VGA_MISSED_FRAME_CNT_EN
    logic [7:0] missed_q;
    logic [7:0] missed_d;

    always_comb begin
        missed_d = missed_q;
        if (vblank_start && irq_q && !irq_if.irq_ack && (missed_q != 8'hFF)) begin
            missed_d = missed_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            missed_q <= 8'h00;
        end else begin
            missed_q <= missed_d;
        end
    end

    assign irq_if.missed_cnt = missed_q;
`else
    assign irq_if.missed_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench: default-timing line checks plus a tiny-raster frame/irq instance
module tb_vga_timing_gen;

    typedef struct packed {
        int hv; int hf; int hsy; int hb;
        int vv; int vf; int vsy; int vb;
    } tim_t;

    typedef struct packed {
        bit pclk; int x; int y; bit tog; bit irq; int miss; bit vbs;
    } mst_t;

    localparam tim_t TD = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam tim_t TS = '{4, 1, 2, 1, 4, 1, 1, 2};
    localparam int MAX_CYC = 60000;
`ifdef VGA_MISSED_FRAME_CNT_EN
    localparam bit CNT_EN   = 1'b1;
    localparam int EXP_MISS = 255;
`else
    localparam bit CNT_EN   = 1'b0;
    localparam int EXP_MISS = 0;
`endif
    localparam logic [63:0] RESET_WORD = {29'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0};

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    logic       pclk_d, pce_d, hs_d, vs_d, blank_d;
    logic [9:0] x_d, y_d;
    logic       pclk_s, pce_s, hs_s, vs_s, blank_s;
    logic [9:0] x_s, y_s;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_s ();

    vga_timing_gen dut_d (
        .CLK(clk), .RESET(rst), .pixel_clk(pclk_d), .pixel_ce(pce_d),
        .DrawX(x_d), .DrawY(y_d), .hs(hs_d), .vs(vs_d), .blank(blank_d), .irq_if(if_d)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2)
    ) dut_s (
        .CLK(clk), .RESET(rst), .pixel_clk(pclk_s), .pixel_ce(pce_s),
        .DrawX(x_s), .DrawY(y_s), .hs(hs_s), .vs(vs_s), .blank(blank_s), .irq_if(if_s)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] q_d[$];
    logic [63:0] q_s[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic mst_t step(input mst_t s, input tim_t t, input bit r, input bit ack);
        mst_t n;
        int ht, vt;
        n = s;
        ht = t.hv + t.hf + t.hsy + t.hb;
        vt = t.vv + t.vf + t.vsy + t.vb;
        n.vbs = 1'b0;
        if (r) begin
            n = '0;
            return n;
        end
        n.pclk = !s.pclk;
        if (!s.pclk) begin
            n.x = s.x + 1;
            if (n.x == ht) begin
                n.x = 0;
                n.y = s.y + 1;
                if (n.y == vt) n.y = 0;
            end
            n.vbs = (n.x == 0) && (n.y == t.vv);
        end
        if (n.vbs) begin
            n.tog = !s.tog;
            n.irq = 1'b1;
            if (CNT_EN && s.irq && !ack && s.miss < 255) n.miss = s.miss + 1;
        end else if (ack) begin
            n.irq = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [63:0] expect_word(input mst_t s, input tim_t t);
        bit h, v, b;
        h = !((s.x >= t.hv + t.hf) && (s.x < t.hv + t.hf + t.hsy));
        v = !((s.y >= t.vv + t.vf) && (s.y < t.vv + t.vf + t.vsy));
        b = (s.x < t.hv) && (s.y < t.vv);
        return {29'd0, s.pclk, !s.pclk, h, v, b, s.tog, s.irq, 10'(s.x), 10'(s.y), 8'(s.miss)};
    endfunction

    // Directed tallies, compared against hand-computed constants at the end.
    int hs_low_cnt = 0, hs_min = 9999, hs_max = -1, bl_min = 9999;
    int vs_min = 9999, vs_max = -1;
    int pce_cnt = 0, frame_len = -1;
    bit have_flip = 1'b0, tog_prev = 1'b0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (q_d.size() > 0) begin
            e = q_d.pop_front();
            check("sb_default", {29'd0, pclk_d, pce_d, hs_d, vs_d, blank_d, if_d.vsync_toggle,
                                 if_d.vblank_irq, x_d, y_d, if_d.missed_cnt}, e);
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            check("sb_small", {29'd0, pclk_s, pce_s, hs_s, vs_s, blank_s, if_s.vsync_toggle,
                               if_s.vblank_irq, x_s, y_s, if_s.missed_cnt}, e);
        end
        if (!rst && pce_d && y_d == 10'd0) begin
            if (!hs_d) begin
                hs_low_cnt++;
                if (int'(x_d) < hs_min) hs_min = int'(x_d);
                if (int'(x_d) > hs_max) hs_max = int'(x_d);
            end
            if (!blank_d && int'(x_d) < bl_min) bl_min = int'(x_d);
        end
        if (!rst && pce_s && !vs_s) begin
            if (int'(y_s) < vs_min) vs_min = int'(y_s);
            if (int'(y_s) > vs_max) vs_max = int'(y_s);
        end
        if (if_s.vsync_toggle != tog_prev) begin
            if (have_flip && frame_len < 0) frame_len = pce_cnt;
            have_flip = 1'b1;
            pce_cnt = 0;
        end
        tog_prev = if_s.vsync_toggle;
        if (pce_s) pce_cnt++;
    end

    initial begin
        mst_t ss, sd, pk;
        int ev, since, rst_cyc, coinc_cyc;
        bit did_reset, finished;
        ss = '0; sd = '0;
        ev = 0; since = 0; rst_cyc = -10; coinc_cyc = -10;
        did_reset = 1'b0; finished = 1'b0;
        rst = 1'b1;
        if_s.irq_ack = 1'b0;
        if_d.irq_ack = 1'b0;
        for (int cyc = 0; cyc < MAX_CYC && !finished; cyc++) begin
            @(posedge clk);
            ss = step(ss, TS, rst, if_s.irq_ack);
            sd = step(sd, TD, rst, 1'b0);
            q_s.push_back(expect_word(ss, TS));
            q_d.push_back(expect_word(sd, TD));
            if (ss.vbs) begin ev++; since = 0; end else since++;
            #1;
            if (cyc == coinc_cyc + 1) begin
                check("coincident_ack_irq", {63'd0, if_s.vblank_irq}, 64'd1);
                check("coincident_ack_missed", {56'd0, if_s.missed_cnt}, 64'd0);
            end
            if (did_reset && cyc == rst_cyc + 1) begin
                check("reset_default", {29'd0, pclk_d, pce_d, hs_d, vs_d, blank_d, if_d.vsync_toggle,
                                        if_d.vblank_irq, x_d, y_d, if_d.missed_cnt}, RESET_WORD);
                check("reset_small", {29'd0, pclk_s, pce_s, hs_s, vs_s, blank_s, if_s.vsync_toggle,
                                      if_s.vblank_irq, x_s, y_s, if_s.missed_cnt}, RESET_WORD);
            end
            if (did_reset && cyc == rst_cyc + 300) finished = 1'b1;
            rst = (cyc < 2);
            if_s.irq_ack = 1'b0;
            if (ev == 1 && since == 10) if_s.irq_ack = 1'b1;
            if (ev == 2) begin
                pk = step(ss, TS, 1'b0, 1'b0);
                if (pk.vbs) begin
                    if_s.irq_ack = 1'b1;
                    coinc_cyc = cyc;
                end
            end
            if (ev == 305 && since == 5) begin
                check("missed_saturated", {56'd0, if_s.missed_cnt}, 64'(EXP_MISS));
                if_s.irq_ack = 1'b1;
            end
            if (!did_reset && ev >= 305 && since > 6 && sd.x == 400) begin
                rst = 1'b1;
                did_reset = 1'b1;
                rst_cyc = cyc;
            end
        end
        if (!finished) check("scenario_timeout", 64'd0, 64'd1);
        @(negedge clk);
        #1;
        check("sb_drained", 64'(q_d.size() + q_s.size()), 64'd0);
        check("hs_low_px", 64'(hs_low_cnt), 64'd96);
        check("hs_first_x", 64'(hs_min), 64'd656);
        check("hs_last_x", 64'(hs_max), 64'd751);
        check("blank_first_x", 64'(bl_min), 64'd640);
        check("vs_low_first_y", 64'(vs_min), 64'd5);
        check("vs_low_last_y", 64'(vs_max), 64'd5);
        check("frame_pce_count", 64'(frame_len), 64'd64);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
